// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit.
//   ADDR_W_DEF   : default PC / word-address width
//   RESET_PC_DEF : default fetch address after reset
//   INSTR_W      : instruction word width
package instr_fetch_unit_pkg;
  localparam int ADDR_W_DEF   = 32;
  localparam int RESET_PC_DEF = 0;
  localparam int INSTR_W      = 32;
endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Fetch queue: synchronous FIFO of DEPTH x (instr, pc).
//   clk/rst       : clock, async active-high reset
//   push_i        : enqueue instr_i/pc_i at the clock edge
//   pop_i         : dequeue head (caller guarantees non-empty)
//   flush_i       : empty the queue; wins over push
//   occ_o         : current occupancy
//   head_*_o      : head entry, valid when head_vld_o
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [CW-1:0]     occ_o,
  output logic              head_vld_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0] head_pc_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][INSTR_W-1:0] instr_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  pc_q;
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] occ_q;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      occ_q   <= '0;
    end else if (flush_i) begin
      // Pointers rewind; stale payload stays but is never visible as valid.
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) begin
        instr_q[wr_q] <= instr_i;
        pc_q[wr_q]    <= pc_i;
        wr_q          <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      // Push+pop on a full queue keeps the count; order is kept by the pointers.
      occ_q <= occ_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign occ_o        = occ_q;
  assign head_vld_o   = (occ_q != '0);
  assign head_instr_o = instr_q[rd_q];
  assign head_pc_o    = pc_q[rd_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to a 1-cycle synchronous imem,
// queues returned words with their PC, hands them out valid/ready, and
// flushes/restarts on redirect.
//   clk, rst              : clock, async active-high reset
//   imem_req/imem_addr    : read request and word address (= fetch PC)
//   imem_data             : read data, valid the cycle after imem_req
//   redirect/redirect_pc  : flush and restart fetch at redirect_pc
//   instr/instr_pc/instr_valid/instr_ready : core-side handshake
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     occ;
  logic              pop, push;
  logic [CW:0]       credit_use;

  assign pop  = instr_valid && instr_ready;
  // A response landing in a redirect cycle belongs to the old path.
  assign push = inflight_q && !redirect;

  // Queued + in-flight, less what leaves this cycle; pop implies occ >= 1 so
  // this never underflows. Redirect already blocks the request, so pops in a
  // redirect cycle cannot earn credit.
  assign credit_use = (CW + 1)'(occ) + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign imem_req   = !rst && !redirect && (credit_use < (CW + 1)'(DEPTH));
  assign imem_addr  = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (imem_req) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 1'b1;  // wraps modulo 2^ADDR_W
    end
    if (redirect) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= ADDR_W'(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CW(CW)) u_fq (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirect),
    .instr_i      (imem_data),
    .pc_i         (req_pc_q),
    .occ_o        (occ),
    .head_vld_o   (instr_valid),
    .head_instr_o (instr),
    .head_pc_o    (instr_pc)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;

  int checks = 0;
  int fails  = 0;
  int nreq;

  instr_fetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory model: word at addr is addr+0x100, one cycle after the request.
  always @(posedge clk) if (imem_req) imem_data <= imem_addr + 32'h100;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Head entry check: valid plus instr/pc.
  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".pc"}, instr_pc, pc);
    chk({tag, ".instr"}, instr, pc + 32'h100);
  endtask

  initial begin
    // ---- reset state
    tick(); tick(); #1;
    chk("rst.req",   {31'd0, imem_req},    32'd0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.instr", instr,    32'd0);
    chk("rst.pc",    instr_pc, 32'd0);
    chk("rst.addr",  imem_addr, 32'd0);

    // ---- streaming with ready=1
    rst = 1'b0; #1;
    chk("s.req0",  {31'd0, imem_req}, 32'd1);
    chk("s.addr0", imem_addr, 32'd0);
    tick(); #1;
    chk("s.addr1",  imem_addr, 32'd1);
    chk("s.valid1", {31'd0, instr_valid}, 32'd0);
    for (int k = 2; k < 8; k++) begin
      tick(); #1;
      chk("s.req", {31'd0, imem_req}, 32'd1);
      chk("s.addr", imem_addr, 32'(k));
      chk_head("s.head", 32'(k - 2));
    end

    // ---- backpressure from reset
    rst = 1'b1; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    nreq = 0;
    for (int k = 0; k < 6; k++) begin
      if (imem_req) nreq++;
      if (k < 5) tick(); else #1;
    end
    chk("bp.nreq", 32'(nreq), 32'd2);
    chk("bp.addr_hold", imem_addr, 32'd2);
    chk_head("bp.head0", 32'd0);
    instr_ready = 1'b1; #1;
    chk("bp.resume_req", {31'd0, imem_req}, 32'd1);
    chk("bp.resume_addr", imem_addr, 32'd2);
    tick(); #1;
    chk_head("bp.head1", 32'd1);
    tick(); #1;
    chk_head("bp.head2", 32'd2);

    // ---- redirect with one queued and one in flight (steady state)
    redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b0; #1;
    chk("rd.req_blocked", {31'd0, imem_req}, 32'd0);
    tick(); redirect = 1'b0; #1;
    chk("rd.flushed", {31'd0, instr_valid}, 32'd0);
    chk("rd.req1", {31'd0, imem_req}, 32'd1);
    chk("rd.addr1", imem_addr, 32'h40);
    tick(); #1;
    chk("rd.nostale", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk_head("rd.new", 32'h40);

    // ---- redirect to the top of the address space, wrap to 0
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; instr_ready = 1'b1;
    tick(); redirect = 1'b0; #1;
    chk("wr.addr", imem_addr, 32'hFFFF_FFFF);
    tick(); #1;
    chk("wr.addr_wrap", imem_addr, 32'h0);
    tick(); #1;
    chk_head("wr.h0", 32'hFFFF_FFFF);
    tick(); #1;
    chk_head("wr.h1", 32'h0);
    tick(); #1;
    chk_head("wr.h2", 32'h1);

    // ---- reset mid-operation (queued + in flight)
    rst = 1'b1; #1;
    chk("mr.valid", {31'd0, instr_valid}, 32'd0);
    chk("mr.req",   {31'd0, imem_req},    32'd0);
    tick();
    rst = 1'b0; #1;
    chk("mr.addr", imem_addr, 32'd0);
    tick(); #1;
    chk("mr.nolate", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk_head("mr.h0", 32'd0);
    tick(); #1;
    chk_head("mr.h1", 32'd1);

    // ---- pop and redirect in the same cycle
    redirect = 1'b1; redirect_pc = 32'h80; #1;
    chk("pr.popped_pc", instr_pc, 32'd1);
    tick(); redirect = 1'b0; #1;
    chk("pr.flushed", {31'd0, instr_valid}, 32'd0);
    chk("pr.addr", imem_addr, 32'h80);
    tick(); #1;
    chk("pr.empty2", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk_head("pr.next", 32'h80);

    // ---- back-to-back redirects: last wins
    redirect = 1'b1; redirect_pc = 32'h10;
    tick(); redirect_pc = 32'h20;
    tick(); redirect = 1'b0; #1;
    chk("bb.addr", imem_addr, 32'h20);
    chk("bb.valid", {31'd0, instr_valid}, 32'd0);
    tick(); tick(); #1;
    chk_head("bb.head", 32'h20);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
